ex_stage: RTL and testbench

- Execute stage of the 5-stage RV32 pipeline. Consumes the ID/EX register outputs and produces the EX/MEM pipeline register.
- Contains:
  - operand forwarding from EX/MEM and MEM/WB
  - the ALU
  - branch resolution (BEQ/BNE), with redirect/flush outputs to fetch/decode
  - the registered EX/MEM state consumed by the memory stage
- Load-use stalls are generated upstream. This block never needs to forward load data from EX/MEM.

---
 rtl/ex_stage_if.sv | 56 +++++
 rtl/ex_stage.sv | 103 ++++++++++
 tb/tb_ex_stage.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_stage_if.sv
// Signal bundle between the ID/EX register, the execute stage and the memory stage.
// The master side drives the ID/EX and MEM/WB inputs; the slave side is the execute stage itself.
interface ex_stage_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  logic              stall;
  logic [XLEN-1:0]   rd1_in;
  logic [XLEN-1:0]   rd2_in;
  logic [XLEN-1:0]   imm_in;
  logic [XLEN-1:0]   imm_b_in;
  logic [XLEN-1:0]   pc_plus4_in;
  logic [REG_AW-1:0] rd_in;
  logic [REG_AW-1:0] rs1_in;
  logic [REG_AW-1:0] rs2_in;
  logic              reg_we_in;
  logic              alu_src_in;
  logic              mem_we_in;
  logic              mem_to_reg_in;
  logic              branch_in;
  logic              branch_ne_in;
  logic [2:0]        alu_ctrl_in;
  logic              wb_reg_we_in;
  logic [REG_AW-1:0] wb_rd_in;
  logic [XLEN-1:0]   wb_data_in;

  logic [XLEN-1:0]   alu_result_out;
  logic [XLEN-1:0]   store_data_out;
  logic [XLEN-1:0]   pc_plus4_out;
  logic [REG_AW-1:0] rd_out;
  logic              reg_we_out;
  logic              mem_we_out;
  logic              mem_to_reg_out;
  logic              branch_taken_out;
  logic [XLEN-1:0]   branch_target_out;

  modport master (
    output stall, rd1_in, rd2_in, imm_in, imm_b_in, pc_plus4_in,
           rd_in, rs1_in, rs2_in, reg_we_in, alu_src_in, mem_we_in,
           mem_to_reg_in, branch_in, branch_ne_in, alu_ctrl_in,
           wb_reg_we_in, wb_rd_in, wb_data_in,
    input  alu_result_out, store_data_out, pc_plus4_out, rd_out,
           reg_we_out, mem_we_out, mem_to_reg_out,
           branch_taken_out, branch_target_out
  );

  modport slave (
    input  stall, rd1_in, rd2_in, imm_in, imm_b_in, pc_plus4_in,
           rd_in, rs1_in, rs2_in, reg_we_in, alu_src_in, mem_we_in,
           mem_to_reg_in, branch_in, branch_ne_in, alu_ctrl_in,
           wb_reg_we_in, wb_rd_in, wb_data_in,
    output alu_result_out, store_data_out, pc_plus4_out, rd_out,
           reg_we_out, mem_we_out, mem_to_reg_out,
           branch_taken_out, branch_target_out
  );
endinterface

// File: rtl/ex_stage.sv
// RV32 execute stage: operand forwarding, ALU, BEQ/BNE resolution and the EX/MEM register.
// Load data is never forwarded from EX/MEM because load-use hazards are stalled upstream.
module ex_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input logic     clk,
  input logic     reset,
  ex_stage_if.slave bus
);

  logic [XLEN-1:0]   alu_q;
  logic [XLEN-1:0]   store_q;
  logic [XLEN-1:0]   pc4_q;
  logic [REG_AW-1:0] rd_q;
  logic              reg_we_q;
  logic              mem_we_q;
  logic              mem_to_reg_q;

  logic [XLEN-1:0]   fwd_a;
  logic [XLEN-1:0]   fwd_b;
  logic [XLEN-1:0]   op_b;
  logic [XLEN-1:0]   alu_y;
  logic              eq;
  logic              taken;

  // Newest producer wins; x0 is hardwired and never takes a forwarded value.
  function automatic logic [XLEN-1:0] pick_operand(
    input logic [REG_AW-1:0] rs,
    input logic [XLEN-1:0]   stale,
    input logic              ex_ok,
    input logic [REG_AW-1:0] ex_rd,
    input logic [XLEN-1:0]   ex_val,
    input logic              wb_ok,
    input logic [REG_AW-1:0] wb_rd,
    input logic [XLEN-1:0]   wb_val
  );
    if (ex_ok && (ex_rd != '0) && (ex_rd == rs)) return ex_val;
    if (wb_ok && (wb_rd != '0) && (wb_rd == rs)) return wb_val;
    return stale;
  endfunction

  always_comb begin
    fwd_a = pick_operand(bus.rs1_in, bus.rd1_in, reg_we_q & ~mem_to_reg_q, rd_q, alu_q,
                         bus.wb_reg_we_in, bus.wb_rd_in, bus.wb_data_in);
    fwd_b = pick_operand(bus.rs2_in, bus.rd2_in, reg_we_q & ~mem_to_reg_q, rd_q, alu_q,
                         bus.wb_reg_we_in, bus.wb_rd_in, bus.wb_data_in);
    op_b  = bus.alu_src_in ? bus.imm_in : fwd_b;
  end

  always_comb begin
    alu_y = '0;
    unique case (bus.alu_ctrl_in)
      3'b000: alu_y = fwd_a + op_b;
      3'b001: alu_y = fwd_a - op_b;
      3'b010: alu_y = fwd_a & op_b;
      3'b011: alu_y = fwd_a | op_b;
      3'b100: alu_y = fwd_a ^ op_b;
      3'b101: alu_y = {{(XLEN-1){1'b0}}, ($signed(fwd_a) < $signed(op_b))};
      3'b110: alu_y = fwd_a << op_b[4:0];
      3'b111: alu_y = fwd_a >> op_b[4:0];
      default: alu_y = '0;
    endcase
  end

  // Branches compare register operands only, so the immediate mux is bypassed here.
  always_comb begin
    eq    = (fwd_a == fwd_b);
    taken = (bus.branch_in & eq) | (bus.branch_ne_in & ~eq);
  end

  assign bus.branch_taken_out  = taken & ~bus.stall & ~reset;
  assign bus.branch_target_out = bus.pc_plus4_in - XLEN'(4) + bus.imm_b_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      alu_q        <= '0;
      store_q      <= '0;
      pc4_q        <= '0;
      rd_q         <= '0;
      reg_we_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_to_reg_q <= 1'b0;
    end else if (!bus.stall) begin
      alu_q        <= alu_y;
      store_q      <= fwd_b;
      pc4_q        <= bus.pc_plus4_in;
      rd_q         <= bus.rd_in;
      reg_we_q     <= bus.reg_we_in;
      mem_we_q     <= bus.mem_we_in;
      mem_to_reg_q <= bus.mem_to_reg_in;
    end
  end

  assign bus.alu_result_out = alu_q;
  assign bus.store_data_out = store_q;
  assign bus.pc_plus4_out   = pc4_q;
  assign bus.rd_out         = rd_q;
  assign bus.reg_we_out     = reg_we_q;
  assign bus.mem_we_out     = mem_we_q;
  assign bus.mem_to_reg_out = mem_to_reg_q;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: a behavioural model predicts each cycle's redirect and EX/MEM
// contents into queues, and a negedge monitor pops and compares them against the DUT.
module tb_ex_stage;

  typedef struct {
    logic        reset;
    logic        stall;
    logic [31:0] rd1, rd2, imm, imm_b, pc4;
    logic [4:0]  rd, rs1, rs2;
    logic        reg_we, alu_src, mem_we, mem_to_reg, branch, branch_ne;
    logic [2:0]  op;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
  } stim_t;

  typedef struct {
    int unsigned tag;
    logic [31:0] alu, store, pc4;
    logic [4:0]  rd;
    logic        reg_we, mem_we, mtr;
  } exmem_t;

  typedef struct {
    logic        taken;
    logic [31:0] target;
  } br_t;

  logic        clk = 1'b0;
  logic        reset;
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  exmem_t model;
  exmem_t reg_q[$];
  br_t    br_q[$];
  exmem_t mon_e;
  br_t    mon_b;

  ex_stage_if #(.XLEN(32), .REG_AW(5)) bus ();

  ex_stage #(.XLEN(32), .REG_AW(5)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Architectural view of an operand: the most recent older instruction that writes it.
  function automatic logic [31:0] ref_operand(input logic [4:0] rs, input logic [31:0] stale, input stim_t s);
    if (rs == 5'd0) return stale;
    if (model.reg_we && !model.mtr && model.rd == rs) return model.alu;
    if (s.wb_we && s.wb_rd == rs) return s.wb_data;
    return stale;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] wide;
    int unsigned sh;
    sh = b % 32;
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      3'd6: begin
        wide = {32'd0, a} * (64'd1 << sh);
        return wide[31:0];
      end
      default: begin
        wide = {32'd0, a} / (64'd1 << sh);
        return wide[31:0];
      end
    endcase
  endfunction

  function automatic stim_t bubble();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s = bubble();
    s.reset      = ($urandom_range(0, 39) == 0);
    s.stall      = ($urandom_range(0, 4) == 0);
    s.rd1        = $urandom;
    s.rd2        = ($urandom_range(0, 3) == 0) ? s.rd1 : $urandom;
    s.imm        = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
    s.imm_b      = $urandom;
    s.pc4        = $urandom;
    s.rd         = 5'($urandom_range(0, 4));
    s.rs1        = 5'($urandom_range(0, 4));
    s.rs2        = 5'($urandom_range(0, 4));
    s.alu_src    = $urandom_range(0, 1) == 1;
    s.op         = 3'($urandom_range(0, 7));
    s.branch     = ($urandom_range(0, 5) == 0);
    s.branch_ne  = !s.branch && ($urandom_range(0, 5) == 0);
    s.reg_we     = !(s.branch || s.branch_ne) && ($urandom_range(0, 3) != 0);
    s.mem_we     = !(s.branch || s.branch_ne) && !s.reg_we && ($urandom_range(0, 1) == 1);
    s.mem_to_reg = s.reg_we && ($urandom_range(0, 7) == 0);
    s.wb_we      = $urandom_range(0, 1) == 1;
    s.wb_rd      = 5'($urandom_range(0, 4));
    s.wb_data    = $urandom;
    return s;
  endfunction

  // Drives one ID/EX cycle and queues what the spec says should come out of it.
  task automatic applyStimulus(input stim_t s);
    logic [31:0] a, b, opb;
    logic        eq, taken;
    exmem_t      nxt;
    br_t         br;

    reset             = s.reset;
    bus.stall         = s.stall;
    bus.rd1_in        = s.rd1;
    bus.rd2_in        = s.rd2;
    bus.imm_in        = s.imm;
    bus.imm_b_in      = s.imm_b;
    bus.pc_plus4_in   = s.pc4;
    bus.rd_in         = s.rd;
    bus.rs1_in        = s.rs1;
    bus.rs2_in        = s.rs2;
    bus.reg_we_in     = s.reg_we;
    bus.alu_src_in    = s.alu_src;
    bus.mem_we_in     = s.mem_we;
    bus.mem_to_reg_in = s.mem_to_reg;
    bus.branch_in     = s.branch;
    bus.branch_ne_in  = s.branch_ne;
    bus.alu_ctrl_in   = s.op;
    bus.wb_reg_we_in  = s.wb_we;
    bus.wb_rd_in      = s.wb_rd;
    bus.wb_data_in    = s.wb_data;

    a     = ref_operand(s.rs1, s.rd1, s);
    b     = ref_operand(s.rs2, s.rd2, s);
    opb   = s.alu_src ? s.imm : b;
    eq    = (a == b);
    taken = (s.branch && eq) || (s.branch_ne && !eq);
    br.taken  = taken && !s.stall && !s.reset;
    br.target = s.pc4 - 32'd4 + s.imm_b;
    br_q.push_back(br);

    nxt = model;
    if (s.reset) begin
      nxt = '{default: '0};
    end else if (!s.stall) begin
      nxt.alu    = ref_alu(s.op, a, opb);
      nxt.store  = b;
      nxt.pc4    = s.pc4;
      nxt.rd     = s.rd;
      nxt.reg_we = s.reg_we;
      nxt.mem_we = s.mem_we;
      nxt.mtr    = s.mem_to_reg;
    end
    nxt.tag = cyc;
    reg_q.push_back(nxt);
    model = nxt;

    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (br_q.size() > 0) begin
      mon_b = br_q.pop_front();
      checkOutput("branch_taken", {31'd0, bus.branch_taken_out}, {31'd0, mon_b.taken});
      if (mon_b.taken) checkOutput("branch_target", bus.branch_target_out, mon_b.target);
    end
    while (reg_q.size() > 0 && reg_q[0].tag < cyc) begin
      mon_e = reg_q.pop_front();
      checkOutput("alu_result", bus.alu_result_out, mon_e.alu);
      checkOutput("store_data", bus.store_data_out, mon_e.store);
      checkOutput("pc_plus4", bus.pc_plus4_out, mon_e.pc4);
      checkOutput("rd", {27'd0, bus.rd_out}, {27'd0, mon_e.rd});
      checkOutput("reg_we", {31'd0, bus.reg_we_out}, {31'd0, mon_e.reg_we});
      checkOutput("mem_we", {31'd0, bus.mem_we_out}, {31'd0, mon_e.mem_we});
      checkOutput("mem_to_reg", {31'd0, bus.mem_to_reg_out}, {31'd0, mon_e.mtr});
    end
  end

  initial begin
    stim_t s;
    model = '{default: '0};
    reset = 1'b1;
    s = bubble();
    s.reset = 1'b1;
    bus.stall = 1'b0;
    @(posedge clk);
    #1;

    // reset together with stall still clears
    s = bubble(); s.reset = 1'b1; s.stall = 1'b1;
    applyStimulus(s);

    // ADD x3,x1,x2 -> 12
    s = bubble(); s.rs1 = 1; s.rs2 = 2; s.rd = 3; s.rd1 = 5; s.rd2 = 7; s.reg_we = 1;
    applyStimulus(s);
    // SUB x4,x3,x1 with x3 from EX/MEM -> 7
    s = bubble(); s.op = 3'd1; s.rs1 = 3; s.rs2 = 1; s.rd = 4; s.rd1 = 0; s.rd2 = 5; s.reg_we = 1;
    applyStimulus(s);
    // same, x3 only in MEM/WB -> 7
    s.wb_we = 1; s.wb_rd = 3; s.wb_data = 12;
    applyStimulus(s);
    // both stages hold x3: EX/MEM 12 beats WB 99
    s = bubble(); s.rs1 = 1; s.rs2 = 2; s.rd = 3; s.rd1 = 5; s.rd2 = 7; s.reg_we = 1;
    applyStimulus(s);
    s = bubble(); s.op = 3'd1; s.rs1 = 3; s.rs2 = 1; s.rd = 4; s.rd1 = 0; s.rd2 = 5; s.reg_we = 1;
    s.wb_we = 1; s.wb_rd = 3; s.wb_data = 99;
    applyStimulus(s);

    // write to x0, then read x0: no forwarding
    s = bubble(); s.alu_src = 1; s.imm = 55; s.rd = 0; s.reg_we = 1;
    applyStimulus(s);
    s = bubble(); s.rd = 5; s.reg_we = 1;
    applyStimulus(s);

    // BEQ taken, target 0xF8; BNE not taken
    s = bubble(); s.rs1 = 6; s.rs2 = 7; s.rd1 = 9; s.rd2 = 9; s.pc4 = 32'h104; s.imm_b = 32'hFFFF_FFF8; s.branch = 1;
    applyStimulus(s);
    s.branch = 0; s.branch_ne = 1;
    applyStimulus(s);

    // three stalled cycles holding a pending BEQ, then release
    s = bubble(); s.rs1 = 9; s.rs2 = 10; s.rd = 8; s.rd1 = 1; s.rd2 = 2; s.reg_we = 1;
    applyStimulus(s);
    s = bubble(); s.rs1 = 6; s.rs2 = 7; s.rd1 = 9; s.rd2 = 9; s.pc4 = 32'h104; s.imm_b = 32'hFFFF_FFF8; s.branch = 1;
    s.stall = 1;
    for (int i = 0; i < 3; i++) applyStimulus(s);
    s.stall = 0;
    applyStimulus(s);
    applyStimulus(bubble());

    // reset asserted mid-stall with non-zero EX/MEM
    s = bubble(); s.rd1 = 32'h1234; s.rd2 = 32'h10; s.rs1 = 1; s.rs2 = 2; s.rd = 7; s.reg_we = 1; s.mem_we = 1; s.pc4 = 32'h40;
    applyStimulus(s);
    s.stall = 1;
    applyStimulus(s);
    s.reset = 1;
    applyStimulus(s);

    // SLT -1<1, SRL 0x80000000>>31, SLL by 33
    s = bubble(); s.op = 3'd5; s.rs1 = 1; s.rs2 = 2; s.rd = 1; s.rd1 = 32'hFFFF_FFFF; s.rd2 = 1; s.reg_we = 1;
    applyStimulus(s);
    s = bubble(); s.op = 3'd7; s.rs1 = 2; s.rd = 2; s.rd1 = 32'h8000_0000; s.alu_src = 1; s.imm = 31; s.reg_we = 1;
    applyStimulus(s);
    s = bubble(); s.op = 3'd6; s.rs1 = 3; s.rd = 3; s.rd1 = 3; s.alu_src = 1; s.imm = 33; s.reg_we = 1;
    applyStimulus(s);

    for (int i = 0; i < 400; i++) applyStimulus(rand_stim());

    applyStimulus(bubble());
    @(negedge clk);
    #1;
    checkOutput("queue_drain", 32'(reg_q.size() + br_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
